// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX/MEM/WB destination tracking, registered EX operand selects, load-use stall.
// HAZARD_FWD_EN defined: forwarding with load-use stall; undefined: selects fixed 00, stall on any RAW vs EX/MEM.
module hazard_forward_ctrl #(
   parameter int REG_BITS = 5,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs1,
   input  logic [REG_BITS-1:0] id_rs2,
   input  logic                id_use_rs2,
   input  logic [REG_BITS-1:0] id_rd,
   input  logic                id_regwrite,
   input  logic                id_memread,
   input  logic                flush,
   output logic                stall,
   output logic [1:0]          fwd_sel_a,
   output logic [1:0]          fwd_sel_b,
   output logic [CNT_BITS-1:0] stall_count
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_WB  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   logic                ex_valid, ex_regwrite, ex_memread;
   logic [REG_BITS-1:0] ex_rd;
   logic                mem_valid, mem_regwrite, mem_memread;
   logic [REG_BITS-1:0] mem_rd;
   logic                wb_valid, wb_regwrite, wb_memread;
   logic [REG_BITS-1:0] wb_rd;

   logic       ex_prod, mem_prod;
   logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic       bubble;
   logic [1:0] sel_a_next, sel_b_next;

   // x0 is hardwired zero, so it never counts as a producer.
   assign ex_prod  = ex_valid  & ex_regwrite  & (ex_rd  != '0);
   assign mem_prod = mem_valid & mem_regwrite & (mem_rd != '0);

   assign ex_hit_a  = ex_prod  & (ex_rd  == id_rs1);
   assign ex_hit_b  = ex_prod  & id_use_rs2 & (ex_rd  == id_rs2);
   assign mem_hit_a = mem_prod & (mem_rd == id_rs1);
   assign mem_hit_b = mem_prod & id_use_rs2 & (mem_rd == id_rs2);

`ifdef HAZARD_FWD_EN
   logic load_hit;

   assign load_hit = ex_valid & ex_memread & (ex_rd != '0) &
                     ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));
   assign stall    = id_valid & ~flush & load_hit;

   // Nearest producer wins: an EX producer is in MEM when the consumer reaches EX.
   always_comb begin
      sel_a_next = SEL_RF;
      sel_b_next = SEL_RF;
      if (id_valid) begin
         if (ex_hit_a)
            sel_a_next = SEL_MEM;
         else if (mem_hit_a)
            sel_a_next = SEL_WB;
         if (ex_hit_b)
            sel_b_next = SEL_MEM;
         else if (mem_hit_b)
            sel_b_next = SEL_WB;
      end
   end
`else
   // Without forwarding the consumer waits in ID until its producer reaches WB.
   assign stall = id_valid & ~flush & (ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b);

   always_comb begin
      sel_a_next = SEL_RF;
      sel_b_next = SEL_RF;
   end
`endif

   assign bubble = flush | stall | ~id_valid;

   // WB record completes the pipeline picture; the register file writes before it reads, so it is never a hazard source.
   logic unused_wb;
   assign unused_wb = ^{wb_valid, wb_regwrite, wb_memread, wb_rd};

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid     <= 1'b0;
         ex_regwrite  <= 1'b0;
         ex_memread   <= 1'b0;
         ex_rd        <= '0;
         mem_valid    <= 1'b0;
         mem_regwrite <= 1'b0;
         mem_memread  <= 1'b0;
         mem_rd       <= '0;
         wb_valid     <= 1'b0;
         wb_regwrite  <= 1'b0;
         wb_memread   <= 1'b0;
         wb_rd        <= '0;
         fwd_sel_a    <= SEL_RF;
         fwd_sel_b    <= SEL_RF;
      end else begin
         wb_valid     <= mem_valid;
         wb_regwrite  <= mem_regwrite;
         wb_memread   <= mem_memread;
         wb_rd        <= mem_rd;
         mem_valid    <= ex_valid;
         mem_regwrite <= ex_regwrite;
         mem_memread  <= ex_memread;
         mem_rd       <= ex_rd;
         if (bubble) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_rd       <= '0;
            fwd_sel_a   <= SEL_RF;
            fwd_sel_b   <= SEL_RF;
         end else begin
            ex_valid    <= 1'b1;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_rd       <= id_rd;
            fwd_sel_a   <= sel_a_next;
            fwd_sel_b   <= sel_b_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_count <= '0;
      else if (stall && (stall_count != CNT_MAX))
         stall_count <= stall_count + CNT_ONE;
   end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard and forwarding controller for the 5-stage datapath. Tracks destination-register info for the instructions in EX, MEM and WB. Generates registered 2-bit select codes for the EX-stage operand `mux4to1` instances (A and B), and raises a load-use stall toward IF/ID. Sits between ID decode and the EX operand muxes.

## Interface
Parameters:
- `REG_BITS`, 5, register-specifier width.
- `CNT_BITS`, 16, width of the stall performance counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`  in  REG_BITS  source register 1 of the ID instruction.
- `id_rs2`  in  REG_BITS  source register 2 of the ID instruction.
- `id_use_rs2`  in  1  ID instruction reads rs2 (0 for immediate forms).
- `id_rd`  in  REG_BITS  destination of the ID instruction.
- `id_regwrite`  in  1  ID instruction writes `id_rd`.
- `id_memread`  in  1  ID instruction is a load.
- `flush`  in  1  branch or jump taken in EX; kill the instruction entering EX.
- `stall`  out  1  combinational; hold PC and IF/ID this cycle.
- `fwd_sel_a`  out  2  registered; EX operand-A mux select.
- `fwd_sel_b`  out  2  registered; EX operand-B mux select.
- `stall_count`  out  CNT_BITS  saturating count of stall cycles.

## Operation
- Internal stage records `ex_*`, `mem_*`, `wb_*`. Each record holds `valid`, `rd`, `regwrite`, `memread`.
- A producer counts only if `valid & regwrite & rd != 0`. Register x0 is never a hazard and is never forwarded.
- Select codes:
  - 00: register file.
  - 01: WB-stage result.
  - 10: MEM-stage result.
  - 11: reserved, never generated.
- Forward decision, evaluated in ID for the operand the instruction will use in EX:
  - Producer in `ex_*` matches → code 10 (it will be in MEM next cycle).
  - Else producer in `mem_*` matches → code 01.
  - Else → code 00.
  - Nearest producer wins.
- rs2 match is qualified by `id_use_rs2`. When it is 0, `fwd_sel_b` is 00.
- Load-use: `stall = id_valid & ~flush & ex_valid & ex_memread & ex_rd != 0 & (ex_rd == id_rs1 | (id_use_rs2 & ex_rd == id_rs2))`.
- The register file writes before it reads. A producer in `wb_*` while the consumer is in ID needs no forwarding.
- Per clock, when not reset:
  - `wb <= mem`; `mem <= ex`.
  - If `flush | stall`: `ex.valid <= 0`, and `fwd_sel_a` and `fwd_sel_b` are set to 00 (bubble).
  - Else: `ex <= id_*`, and the selects take the computed codes.
- `stall_count` increments on each cycle with `stall = 1` and saturates at all-ones.

## Timing
- Reset values:
  - All stage `valid` = 0.
  - `fwd_sel_a` = `fwd_sel_b` = 00.
  - `stall_count` = 0.
  - `stall` = 0, which follows from `ex.valid` = 0.
- Select latency: a code computed in cycle N is presented during cycle N+1, aligned with the instruction in EX.
- A load-use stall lasts exactly one cycle. In the next cycle the load is in MEM, so code 10 would be wrong; the consumer re-evaluates and gets 01, because the load is now the `mem_*` producer.
- Simultaneous flush and stall: flush wins; `stall` = 0 and a bubble enters EX.
- Reset mid-operation: all records are cleared in the same edge and there is no pending stall next cycle.
- `id_valid = 0`: no stall is raised, and a bubble with selects 00 enters EX.

## Configuration
- `HAZARD_FWD_EN`
  - Defined: forwarding as above.
  - Undefined:
    - `fwd_sel_a` and `fwd_sel_b` are constant 00.
    - `stall` is raised for any RAW match against a qualifying producer in `ex_*` or `mem_*`, loads or not.
    - A dependent instruction therefore waits until its producer reaches WB: up to 2 stall cycles.
    - `stall_count` behaves identically.

## Test plan
- Reset check: assert `reset` for 2 cycles with arbitrary inputs → `stall` = 0, selects 00, `stall_count` = 0.
- EX→EX forwarding: `add x5` (regwrite) then `sub x6,x5,x7` back-to-back → cycle after the sub is issued, `fwd_sel_a` = 10, `fwd_sel_b` = 00, no stall.
- MEM→EX forwarding and priority:
  - `add x5`; `nop`; `or x8,x5,x5` → `fwd_sel_a` = `fwd_sel_b` = 01.
  - `add x5`; `add x5`; `use x5` → code 10 (nearest producer).
- Load-use: `lw x3`; `add x4,x3,x0` → `stall` = 1 for exactly 1 cycle, EX bubble with selects 00, then the add gets `fwd_sel_a` = 01; `stall_count` = 1.
- x0 and flush:
  - Producer with `rd` = 0 → never forwarded, never stalls.
  - `flush` asserted during a load-use condition → `stall` = 0, bubble in EX, `stall_count` unchanged.
- Without `HAZARD_FWD_EN`: `add x5`; `sub x6,x5,x7` → 2 stall cycles, selects always 00, `stall_count` = 2.
